vga_image_fetch: RTL

VGA_IMAGE_FETCH -- requirements
Module: vga_image_fetch

---
 rtl/vga_image_fetch.sv | 137 +++++++++++++
 1 files changed

// File: rtl/vga_image_fetch.sv
// Streams a FRAME_W x FRAME_H image from a 1-cycle-latency word RAM out of an
// Avalon-ST RGB source, using a small first-word-fall-through FIFO for back-pressure.
module vga_image_fetch #(
    parameter int unsigned FRAME_W    = 640,
    parameter int unsigned FRAME_H    = 400,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic [17:0] ram_address,
    output logic        ram_chipselect,
    output logic        ram_write,
    output logic [3:0]  ram_byteenable,
    output logic        ram_clken,
    input  logic [31:0] ram_readdata,
    output logic [23:0] dout_data,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        dout_startofpacket,
    output logic        dout_endofpacket,
    output logic        frame_done
);

    localparam int unsigned NumPix  = FRAME_W * FRAME_H;
    localparam int unsigned PtrW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW    = PtrW + 1;
    localparam logic [31:0] LastIdx = 32'(NumPix - 1);

    typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

    state_e          state_q, state_d;
    logic [31:0]     idx_q, idx_d;
    logic            inflight_q, infl_sop_q, infl_eop_q;
    logic [CntW-1:0] count_q;
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [25:0]     mem_q [FIFO_DEPTH];
    logic            frame_done_q;
    logic            issue, push, pop;
    logic [25:0]     head;
    logic            unused_hi;

    assign ram_write      = 1'b0;
    assign ram_byteenable = 4'hF;
    assign ram_clken      = 1'b1;
    assign unused_hi      = ^ram_readdata[31:24];

    assign ram_address    = 18'(BASE_ADDR + idx_q);
    assign ram_chipselect = issue;

    // Entry layout: [25] sop, [24] eop, [23:0] RGB
    assign head               = mem_q[rd_ptr_q];
    assign dout_valid         = (count_q != '0);
    assign dout_data          = dout_valid ? head[23:0] : 24'd0;
    assign dout_startofpacket = dout_valid & head[25];
    assign dout_endofpacket   = dout_valid & head[24];
    assign frame_done         = frame_done_q;

    // Read data arrives the cycle after the strobe, so the in-flight flag is the push.
    assign push = inflight_q;
    assign pop  = dout_valid & dout_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        issue   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d = StFetch;
                    idx_d   = '0;
                end
            end
            StFetch: begin
                // Reserve a slot for the outstanding read so the FIFO cannot overflow.
                issue = (32'(count_q) + 32'(inflight_q)) < FIFO_DEPTH;
                if (issue) begin
                    idx_d = idx_q + 32'd1;
                    if (idx_q == LastIdx) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (count_q == '0 && !inflight_q) begin
                    if (enable) begin
                        state_d = StFetch;
                        idx_d   = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            inflight_q   <= 1'b0;
            infl_sop_q   <= 1'b0;
            infl_eop_q   <= 1'b0;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            inflight_q   <= issue;
            infl_sop_q   <= issue && (idx_q == 32'd0);
            infl_eop_q   <= issue && (idx_q == LastIdx);
            frame_done_q <= pop & head[24];
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {infl_sop_q, infl_eop_q, ram_readdata[23:0]};
        end
    end

endmodule
